// File: rtl/note_player.sv
// note_player: plays one note at a time for the song sequencer.
// A note (pitch index + duration in beats) is captured, its phase step is
// fetched from frequency_rom, and sine_reader is driven at the codec's
// sample rate until the beat count runs out. Index 0 is a rest: samples are
// still requested so the codec keeps its cadence, but the audio is silent.

// frequency_rom: phase step per pitch index, registered output (1-cycle latency).
// Steps target a 22-bit phase accumulator at 48 kHz; index 49 is A4 (440 Hz).
// The top octave is tabulated and lower octaves are derived by shifting.
module frequency_rom (
    input  logic        clk,
    input  logic [5:0]  addr,
    output logic [19:0] dout
);

    function automatic logic [19:0] step_lookup(input logic [5:0] note);
        logic [5:0]  key;
        logic [5:0]  semi;
        logic [2:0]  octave;
        logic [19:0] base;
        key = note - 6'd1;
        if (key >= 6'd60) begin
            octave = 3'd5;
            semi   = key - 6'd60;
        end else if (key >= 6'd48) begin
            octave = 3'd4;
            semi   = key - 6'd48;
        end else if (key >= 6'd36) begin
            octave = 3'd3;
            semi   = key - 6'd36;
        end else if (key >= 6'd24) begin
            octave = 3'd2;
            semi   = key - 6'd24;
        end else if (key >= 6'd12) begin
            octave = 3'd1;
            semi   = key - 6'd12;
        end else begin
            octave = 3'd0;
            semi   = key;
        end
        case (semi)
            6'd0:    base = 20'd76896;
            6'd1:    base = 20'd81468;
            6'd2:    base = 20'd86312;
            6'd3:    base = 20'd91445;
            6'd4:    base = 20'd96882;
            6'd5:    base = 20'd102643;
            6'd6:    base = 20'd108747;
            6'd7:    base = 20'd115213;
            6'd8:    base = 20'd122064;
            6'd9:    base = 20'd129322;
            6'd10:   base = 20'd137012;
            6'd11:   base = 20'd145160;
            default: base = 20'd0;
        endcase
        if (note == 6'd0) begin
            step_lookup = 20'd0;
        end else begin
            step_lookup = base >> (3'd5 - octave);
        end
    endfunction

    // Registered table read.
    always_ff @(posedge clk) begin
        dout <= step_lookup(addr);
    end

endmodule

// sine_reader: phase accumulator plus 16-entry sine table.
// A request advances the phase; the sample for the advanced phase is
// presented with sample_ready exactly two cycles after the request.
module sine_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] step_size,
    input  logic        generate_next,
    output logic        sample_ready,
    output logic [15:0] sample
);

    logic [21:0] phase_r;
    logic        req_d1_r;
    logic        ready_r;
    logic [15:0] sample_r;

    function automatic logic [15:0] sine_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    sine_lut = 16'h0000;
            4'd1:    sine_lut = 16'h30FB;
            4'd2:    sine_lut = 16'h5A82;
            4'd3:    sine_lut = 16'h7641;
            4'd4:    sine_lut = 16'h7FFF;
            4'd5:    sine_lut = 16'h7641;
            4'd6:    sine_lut = 16'h5A82;
            4'd7:    sine_lut = 16'h30FB;
            4'd8:    sine_lut = 16'h0000;
            4'd9:    sine_lut = 16'hCF05;
            4'd10:   sine_lut = 16'hA57E;
            4'd11:   sine_lut = 16'h89BF;
            4'd12:   sine_lut = 16'h8001;
            4'd13:   sine_lut = 16'h89BF;
            4'd14:   sine_lut = 16'hA57E;
            4'd15:   sine_lut = 16'hCF05;
            default: sine_lut = 16'h0000;
        endcase
    endfunction

    // Phase advance on request, then a two-stage pipeline to the sample output.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r  <= 22'd0;
            req_d1_r <= 1'b0;
            ready_r  <= 1'b0;
            sample_r <= 16'd0;
        end else begin
            if (generate_next) begin
                phase_r <= phase_r + {2'b00, step_size};
            end else begin
                phase_r <= phase_r;
            end
            req_d1_r <= generate_next;
            ready_r  <= req_d1_r;
            if (req_d1_r) begin
                sample_r <= sine_lut(phase_r[21:18]);
            end else begin
                sample_r <= sample_r;
            end
        end
    end

    assign sample_ready = ready_r;
    assign sample       = sample_r;

endmodule

module note_player #(
    parameter int NOTE_WIDTH = 6,
    parameter int DUR_WIDTH  = 6,
    parameter int STEP_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic                  load_new_note,
    input  logic [NOTE_WIDTH-1:0] note_to_load,
    input  logic [DUR_WIDTH-1:0]  duration_to_load,
    input  logic                  beat,
    input  logic                  generate_next_sample,
    output logic                  done_with_note,
    output logic                  busy,
    output logic                  new_sample_ready,
    output logic [15:0]           sample_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    localparam logic [DUR_WIDTH-1:0] DUR_ONE = DUR_WIDTH'(1);

    state_t                 state_r, state_s;
    logic [NOTE_WIDTH-1:0]  note_r, note_s;
    logic [DUR_WIDTH-1:0]   count_r, count_s;
    logic [STEP_WIDTH-1:0]  step_r, step_s;
    logic                   done_r, done_s;
    logic                   busy_r;

    logic [NOTE_WIDTH-1:0]  rom_addr_s;
    logic [STEP_WIDTH-1:0]  rom_dout_s;
    logic                   sine_reset_s;
    logic                   sine_gen_s;
    logic                   sine_ready_s;
    logic [15:0]            sine_sample_s;
    logic                   rest_s;

    // The ROM sees the incoming note on the load cycle so its registered
    // output is ready during LOAD; the phase restarts on every accepted load.
    assign rom_addr_s   = load_new_note ? note_to_load : note_r;
    assign sine_reset_s = reset | load_new_note;
    assign sine_gen_s   = (state_r == PLAY) & generate_next_sample & play_enable;
    assign rest_s       = (note_r == '0);

    frequency_rom u_rom (
        .clk  (clk),
        .addr (rom_addr_s),
        .dout (rom_dout_s)
    );

    sine_reader u_sine (
        .clk           (clk),
        .reset         (sine_reset_s),
        .step_size     (step_r),
        .generate_next (sine_gen_s),
        .sample_ready  (sine_ready_s),
        .sample        (sine_sample_s)
    );

    // Next-state logic: a load always wins, then LOAD/PLAY sequencing and beat counting.
    always_comb begin
        state_s = state_r;
        note_s  = note_r;
        count_s = count_r;
        step_s  = step_r;
        done_s  = 1'b0;
        if (load_new_note) begin
            state_s = LOAD;
            note_s  = note_to_load;
            count_s = duration_to_load;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                LOAD: begin
                    step_s = rom_dout_s;
                    if (count_r == '0) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = PLAY;
                    end
                end
                PLAY: begin
                    if (beat && play_enable) begin
                        if (count_r == DUR_ONE) begin
                            count_s = '0;
                            state_s = IDLE;
                            done_s  = 1'b1;
                        end else if (count_r != '0) begin
                            count_s = count_r - DUR_ONE;
                        end else begin
                            count_s = '0;
                        end
                    end else begin
                        count_s = count_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and note registers; busy and done are registered from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            note_r  <= '0;
            count_r <= '0;
            step_r  <= '0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            note_r  <= note_s;
            count_r <= count_s;
            step_r  <= step_s;
            done_r  <= done_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Sample forwarding: only while playing; rests and idle output silence.
    // In-flight samples still arrive during a pause because state stays PLAY.
    always_comb begin
        new_sample_ready = (state_r == PLAY) && sine_ready_s;
        if ((state_r == PLAY) && !rest_s) begin
            sample_out = sine_sample_s;
        end else begin
            sample_out = 16'd0;
        end
    end

    assign done_with_note = done_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: stimulus pushes expected samples and
// done pulses (with the cycle they must appear) into queues; a monitor on
// the falling edge pops and compares whenever the DUT presents an output.
module tb_note_player;

    logic        clk = 1'b0;
    logic        reset;
    logic        play_enable;
    logic        load_new_note;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        beat;
    logic        generate_next_sample;
    logic        done_with_note;
    logic        busy;
    logic        new_sample_ready;
    logic [15:0] sample_out;

    note_player dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .load_new_note        (load_new_note),
        .note_to_load         (note_to_load),
        .duration_to_load     (duration_to_load),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .done_with_note       (done_with_note),
        .busy                 (busy),
        .new_sample_ready     (new_sample_ready),
        .sample_out           (sample_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int          cycle;
        logic [15:0] value;
    } sample_exp_t;

    sample_exp_t sample_q[$];
    int          done_q[$];

    // Hand-computed 32767*sin(2*pi*k/16).
    logic signed [15:0] sine_tab [0:15] = '{
        16'sd0, 16'sd12539, 16'sd23170, 16'sd30273,
        16'sd32767, 16'sd30273, 16'sd23170, 16'sd12539,
        16'sd0, -16'sd12539, -16'sd23170, -16'sd30273,
        -16'sd32767, -16'sd30273, -16'sd23170, -16'sd12539
    };

    logic [21:0] phase_m = 22'd0;
    logic [19:0] step_m = 20'd0;
    logic        rest_m = 1'b0;
    logic [15:0] last_sample_m = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare every presented output against the queued expectation.
    always @(negedge clk) begin
        sample_exp_t e;
        if (!reset) begin
            if (sample_q.size() > 0 && sample_q[0].cycle < cyc) begin
                e = sample_q.pop_front();
                check("sample_missing_cycle", 32'(cyc), 32'(e.cycle));
            end
            if (new_sample_ready) begin
                if (sample_q.size() == 0) begin
                    check("sample_unexpected", 32'(new_sample_ready), 32'd0);
                end else begin
                    e = sample_q.pop_front();
                    check("sample_cycle", 32'(cyc), 32'(e.cycle));
                    check("sample_value", 32'(sample_out), 32'(e.value));
                end
            end
            if (done_q.size() > 0 && done_q[0] < cyc) begin
                check("done_missing_cycle", 32'(cyc), 32'(done_q.pop_front()));
            end
            if (done_with_note) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'(done_with_note), 32'd0);
                end else begin
                    check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
                end
            end
        end
    end

    task automatic start_note(input logic [19:0] step, input logic rest);
        phase_m = 22'd0;
        step_m  = step;
        rest_m  = rest;
    endtask

    // Drive one cycle of inputs; a request that should produce audio queues its sample.
    task automatic step_cycle(input logic ld, input logic [5:0] nt, input logic [5:0] du,
                              input logic pe, input logic bt, input logic gn, input logic exp_s);
        logic [15:0] v;
        load_new_note        = ld;
        note_to_load         = nt;
        duration_to_load     = du;
        play_enable          = pe;
        beat                 = bt;
        generate_next_sample = gn;
        if (gn && exp_s) begin
            phase_m = phase_m + {2'b00, step_m};
            v = rest_m ? 16'd0 : sine_tab[phase_m[21:18]];
            last_sample_m = v;
            sample_q.push_back('{cyc + 2, v});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        play_enable = 1'b0;
        load_new_note = 1'b0;
        note_to_load = 6'd0;
        duration_to_load = 6'd0;
        beat = 1'b0;
        generate_next_sample = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done_with_note), 32'd0);
        check("reset_nsr", 32'(new_sample_ready), 32'd0);
        check("reset_sample", 32'(sample_out), 32'd0);

        // Idle with requests toggling: nothing may come out.
        for (int i = 0; i < 20; i++) step_cycle(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'(i % 2), 1'b0);
        check("idle_sample", 32'(sample_out), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Note 49, three beats.
        start_note(20'd38448, 1'b0);
        for (int i = 0; i < 260; i++) begin
            if (i == 1) check("n49_busy_load", 32'(busy), 32'd1);
            if (i == 2) check("n49_step", 32'(dut.step_r), 32'd38448);
            if (i == 250) check("n49_busy_last", 32'(busy), 32'd1);
            if (i == 251) check("n49_busy_fall", 32'(busy), 32'd0);
            if (i == 250) done_q.push_back(cyc + 1);
            step_cycle(i == 0, 6'd49, 6'd3, 1'b1, (i == 50 || i == 150 || i == 250),
                       (i % 8 == 4), (i < 250));
        end

        // Rest note, two beats: pulses continue, audio silent.
        start_note(20'd0, 1'b1);
        for (int i = 0; i < 160; i++) begin
            if (i == 2) check("rest_step", 32'(dut.step_r), 32'd0);
            if (i == 151) check("rest_busy_fall", 32'(busy), 32'd0);
            if (i == 150) done_q.push_back(cyc + 1);
            step_cycle(i == 0, 6'd0, 6'd2, 1'b1, (i == 50 || i == 150),
                       (i % 8 == 4), (i < 150));
        end

        // Four beats with a 500-cycle pause after two; one request in flight at pause.
        start_note(20'd38448, 1'b0);
        for (int i = 0; i < 870; i++) begin
            logic pe;
            pe = !(i >= 200 && i < 700);
            if (i == 400) check("pause_hold_sample", 32'(sample_out), 32'(last_sample_m));
            if (i == 400) check("pause_busy", 32'(busy), 32'd1);
            if (i == 851) check("pause_busy_fall", 32'(busy), 32'd0);
            if (i == 850) done_q.push_back(cyc + 1);
            step_cycle(i == 0, 6'd49, 6'd4, pe, (i % 100 == 50),
                       (i % 8 == 4) || (i == 199), pe && (i < 850));
        end

        // Abort on the final beat with a new note 10, one beat.
        start_note(20'd38448, 1'b0);
        for (int i = 0; i < 260; i++) begin
            if (i == 150) start_note(20'd4041, 1'b0);
            if (i == 151) check("abort_phase_restart", 32'(dut.u_sine.phase_r), 32'd0);
            if (i == 151) check("abort_busy_load", 32'(busy), 32'd1);
            if (i == 152) check("abort_step_n10", 32'(dut.step_r), 32'd4041);
            if (i == 251) check("abort_busy_fall", 32'(busy), 32'd0);
            if (i == 250) done_q.push_back(cyc + 1);
            step_cycle((i == 0 || i == 150), (i < 150) ? 6'd49 : 6'd10, (i < 150) ? 6'd2 : 6'd1,
                       1'b1, (i == 50 || i == 150 || i == 250),
                       (i % 8 == 4) && !(i >= 150 && i < 152),
                       (i < 150) || (i >= 152 && i < 250));
        end

        // Zero-duration note: one LOAD cycle, done two cycles after load.
        start_note(20'd38448, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 1) check("dur0_busy_load", 32'(busy), 32'd1);
            if (i == 2) check("dur0_busy_idle", 32'(busy), 32'd0);
            if (i == 0) done_q.push_back(cyc + 2);
            step_cycle(i == 0, 6'd49, 6'd0, 1'b1, 1'b0, (i % 8 == 4), 1'b0);
        end

        // Reset with a sample in flight: nothing may emerge afterwards.
        start_note(20'd38448, 1'b0);
        for (int i = 0; i < 30; i++) begin
            reset = (i == 21);
            if (i == 22) check("rst_mid_busy", 32'(busy), 32'd0);
            if (i == 22) check("rst_mid_sample", 32'(sample_out), 32'd0);
            step_cycle(i == 0, 6'd49, 6'd1, 1'b1, 1'b0, (i == 20), 1'b0);
        end
        reset = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("sample_q_empty", 32'(sample_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
